// File: rtl/powlib_fifo_arb.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port among N requesters.
// Once a packet's first beat is accepted the grant is held until its last beat is accepted.
module powlib_fifo_arb #(
    parameter int N = 4,
    parameter int W = 16,
    localparam int WIDX = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    wrdata,
    input  logic [N-1:0]      wrvld,
    input  logic [N-1:0]      wrlast,
    output logic [N-1:0]      wrrdy,
    output logic [W-1:0]      outdata,
    output logic              outlast,
    output logic [WIDX-1:0]   outidx,
    output logic              outvld,
    input  logic              outrdy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_q;
    logic [WIDX-1:0]   ptr_q;
    logic [WIDX-1:0]   gidx_q;
    logic [W-1:0]      outdata_q;
    logic              outlast_q;
    logic [WIDX-1:0]   outidx_q;
    logic              outvld_q;

    logic [WIDX-1:0]   rr_sel;
    logic [WIDX-1:0]   sel;
    logic [W-1:0]      outdata_d;
    logic              ld;
    logic              acc;

    function automatic logic [WIDX-1:0] wrap_inc(input logic [WIDX-1:0] v);
        if (v == WIDX'(N - 1)) return '0;
        return v + WIDX'(1);
    endfunction

    // Walk the search order backwards so the first valid port from ptr wins.
    always_comb begin
        int j;
        j      = 0;
        rr_sel = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (wrvld[j]) rr_sel = WIDX'(j);
        end
    end

    assign sel = (state_q == LOCK) ? gidx_q : rr_sel;
    assign ld  = !outvld_q || outrdy;

    always_comb begin
        wrrdy = '0;
        for (int i = 0; i < N; i++) begin
            wrrdy[i] = rst && ld && (sel == WIDX'(i)) && ((state_q == LOCK) || wrvld[i]);
        end
    end

    assign acc       = wrvld[sel] && wrrdy[sel];
    assign outdata_d = wrdata[int'(sel)*W +: W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            outdata_q <= '0;
            outlast_q <= 1'b0;
            outidx_q  <= '0;
            outvld_q  <= 1'b0;
        end else begin
            if (ld) begin
                outvld_q <= acc;
                if (acc) begin
                    outdata_q <= outdata_d;
                    outlast_q <= wrlast[sel];
                    outidx_q  <= sel;
                end
            end
            if (acc) begin
                case (state_q)
                    IDLE: begin
                        if (wrlast[sel]) begin
                            ptr_q <= wrap_inc(sel);
                        end else begin
                            state_q <= LOCK;
                            gidx_q  <= sel;
                        end
                    end
                    LOCK: begin
                        if (wrlast[sel]) begin
                            state_q <= IDLE;
                            ptr_q   <= wrap_inc(sel);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign outdata = outdata_q;
    assign outlast = outlast_q;
    assign outidx  = outidx_q;
    assign outvld  = outvld_q;

endmodule

// File: tb/tb_powlib_fifo_arb.sv
// Bench for powlib_fifo_arb: directed scenarios with literal expectations, then randomized
// traffic, all continuously compared against a queue-free behavioural arbiter model.
module tb_powlib_fifo_arb;

    localparam int N = 4;
    localparam int W = 16;
    localparam int WIDX = 2;

    logic              clk;
    logic              rst;
    logic [N*W-1:0]    wrdata;
    logic [N-1:0]      wrvld;
    logic [N-1:0]      wrlast;
    logic [N-1:0]      wrrdy;
    logic [W-1:0]      outdata;
    logic              outlast;
    logic [WIDX-1:0]   outidx;
    logic              outvld;
    logic              outrdy;

    int checks = 0;
    int errors = 0;

    powlib_fifo_arb #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wrdata  (wrdata),
        .wrvld   (wrvld),
        .wrlast  (wrlast),
        .wrrdy   (wrrdy),
        .outdata (outdata),
        .outlast (outlast),
        .outidx  (outidx),
        .outvld  (outvld),
        .outrdy  (outrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic put(input int i, input logic v, input logic l, input logic [W-1:0] d);
        wrvld[i]        = v;
        wrlast[i]       = l;
        wrdata[i*W +: W] = d;
    endtask

    // Model state: owner of the current packet (-1 if none), round-robin start, output register.
    int          m_own;
    int          m_ptr;
    logic        m_vld;
    logic [W-1:0] m_data;
    logic        m_last;
    int          m_idx;
    int          last_acc;

    // Inputs only change just after a rising edge, so at the falling edge they are the
    // values the next rising edge will act on.
    always @(negedge clk) begin
        logic          ld;
        logic [N-1:0]  erdy;
        logic          a;
        int            g;
        if (!rst) begin
            m_own = -1; m_ptr = 0; m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_idx = 0;
            last_acc = -1;
            chk("model_rst_outvld", 32'(outvld), 32'(0));
            chk("model_rst_wrrdy", 32'(wrrdy), 32'(0));
        end else begin
            chk("model_outvld", 32'(outvld), 32'(m_vld));
            if (m_vld) begin
                chk("model_outdata", 32'(outdata), 32'(m_data));
                chk("model_outlast", 32'(outlast), 32'(m_last));
                chk("model_outidx", 32'(outidx), 32'(m_idx));
            end
            ld = !m_vld || outrdy;
            g = -1;
            if (m_own >= 0) g = m_own;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && wrvld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            erdy = '0;
            if (ld && g >= 0) erdy[g] = 1'b1;
            chk("model_wrrdy", 32'(wrrdy), 32'(erdy));
            a = (g >= 0) && erdy[g] && wrvld[g];
            last_acc = a ? g : -1;
            if (ld) m_vld = a;
            if (a) begin
                m_data = wrdata[g*W +: W];
                m_last = wrlast[g];
                m_idx  = g;
                if (wrlast[g]) begin
                    m_own = -1;
                    m_ptr = (g + 1) % N;
                end else begin
                    m_own = g;
                end
            end
        end
    end

    int bcnt [N];
    int plen [N];
    int seq  [N];
    logic [W-1:0] held;

    initial begin
        rst = 1'b0; wrdata = '0; wrvld = '0; wrlast = '0; outrdy = 1'b0;
        m_own = -1; m_ptr = 0; m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_idx = 0; last_acc = -1;

        // Reset: requests present but must not be acknowledged while rst is low.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) put(i, 1'b1, 1'b1, W'(16'hA000 + i));
        outrdy = 1'b1;
        @(posedge clk); #1;
        chk("rst_outvld", 32'(outvld), 32'(0));
        chk("rst_outdata", 32'(outdata), 32'(0));
        chk("rst_outidx", 32'(outidx), 32'(0));
        chk("rst_outlast", 32'(outlast), 32'(0));
        chk("rst_wrrdy", 32'(wrrdy), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk("tie_first_wrrdy", 32'(wrrdy), 32'(4'b0001));

        // All ports valid with single-beat packets: strict rotation 0,1,2,3,...
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("rr_outvld", 32'(outvld), 32'(1));
            chk("rr_outidx", 32'(outidx), 32'(c % 4));
            chk("rr_outdata", 32'(outdata), 32'(16'hA000 + (c % 4)));
            chk("rr_wrrdy", 32'(wrrdy), 32'(1 << ((c + 1) % 4)));
        end
        wrvld = '0; wrlast = '0;
        @(posedge clk); #1;
        chk("drain_outvld", 32'(outvld), 32'(0));

        // Port1 three-beat packet while port2 waits.
        put(2, 1'b1, 1'b1, 16'hB001);
        for (int b = 0; b < 3; b++) begin
            put(1, 1'b1, (b == 2), W'(16'hA101 + b));
            #1 chk("lock_wrrdy", 32'(wrrdy), 32'(4'b0010));
            @(posedge clk); #1;
            chk("lock_outdata", 32'(outdata), 32'(16'hA101 + b));
            chk("lock_outlast", 32'(outlast), 32'(b == 2));
        end
        put(1, 1'b0, 1'b0, '0);
        #1 chk("after_lock_wrrdy", 32'(wrrdy), 32'(4'b0100));
        @(posedge clk); #1;
        chk("after_lock_outdata", 32'(outdata), 32'(16'hB001));
        chk("after_lock_outidx", 32'(outidx), 32'(2));

        // Lock on port0 with a four-cycle gap; port3 must not be served meanwhile.
        put(2, 1'b0, 1'b0, '0);
        put(0, 1'b1, 1'b0, 16'hC001);
        #1 chk("gap_start_wrrdy", 32'(wrrdy), 32'(4'b0001));
        @(posedge clk); #1;
        chk("gap_start_outidx", 32'(outidx), 32'(0));
        put(0, 1'b0, 1'b0, '0);
        put(3, 1'b1, 1'b1, 16'hD001);
        for (int c = 0; c < 4; c++) begin
            #1 chk("gap_wrrdy", 32'(wrrdy), 32'(4'b0001));
            @(posedge clk); #1;
            chk("gap_outvld", 32'(outvld), 32'(0));
        end
        put(0, 1'b1, 1'b1, 16'hC002);
        #1 chk("gap_end_wrrdy", 32'(wrrdy), 32'(4'b0001));
        @(posedge clk); #1;
        chk("gap_end_outdata", 32'(outdata), 32'(16'hC002));
        chk("gap_end_outidx", 32'(outidx), 32'(0));
        put(0, 1'b0, 1'b0, '0);
        #1 chk("port3_wrrdy", 32'(wrrdy), 32'(4'b1000));
        @(posedge clk); #1;
        chk("port3_outdata", 32'(outdata), 32'(16'hD001));

        // Downstream stall: output must hold while port3 presents a new beat.
        outrdy = 1'b0;
        put(3, 1'b1, 1'b1, 16'hD002);
        held = outdata;
        #1 chk("stall_wrrdy0", 32'(wrrdy), 32'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_outvld", 32'(outvld), 32'(1));
            chk("stall_outdata", 32'(outdata), 32'(held));
            chk("stall_outidx", 32'(outidx), 32'(3));
            chk("stall_wrrdy", 32'(wrrdy), 32'(0));
        end
        outrdy = 1'b1;
        #1 chk("release_wrrdy", 32'(wrrdy), 32'(4'b1000));

        // Only port3 requesting: accepted every cycle across the pointer wrap.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("solo_outvld", 32'(outvld), 32'(1));
            chk("solo_outidx", 32'(outidx), 32'(3));
            chk("solo_outdata", 32'(outdata), 32'(16'hD002));
        end

        // Reset in the middle of a port1 packet.
        put(3, 1'b0, 1'b0, '0);
        put(1, 1'b1, 1'b0, 16'hE001);
        #1 chk("pre_rst_wrrdy", 32'(wrrdy), 32'(4'b0010));
        @(posedge clk); #1;
        chk("pre_rst_outvld", 32'(outvld), 32'(1));
        #1 rst = 1'b0;
        #1;
        chk("async_rst_outvld", 32'(outvld), 32'(0));
        chk("async_rst_wrrdy", 32'(wrrdy), 32'(0));
        for (int i = 0; i < N; i++) put(i, 1'b1, 1'b1, W'(16'hF000 + i));
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk("post_rst_wrrdy", 32'(wrrdy), 32'(4'b0001));
        @(posedge clk); #1;
        chk("post_rst_outidx", 32'(outidx), 32'(0));
        chk("post_rst_outdata", 32'(outdata), 32'(16'hF000));

        // Randomized multi-beat traffic with random downstream backpressure.
        for (int i = 0; i < N; i++) begin
            bcnt[i] = 0;
            plen[i] = $urandom_range(1, 4);
            seq[i]  = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            if (last_acc >= 0) begin
                seq[last_acc]++;
                if (bcnt[last_acc] == plen[last_acc] - 1) begin
                    bcnt[last_acc] = 0;
                    plen[last_acc] = $urandom_range(1, 4);
                end else begin
                    bcnt[last_acc]++;
                end
            end
            for (int i = 0; i < N; i++) begin
                put(i, ($urandom_range(0, 99) < 60), (bcnt[i] == plen[i] - 1),
                    {4'(i), 12'(seq[i])});
            end
            outrdy = ($urandom_range(0, 99) < 70);
            rst = !(c == 1500 || c == 1501);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        wrvld = '0;
        outrdy = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_outvld", 32'(outvld), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
